// File: rtl/md5_pkg.sv
// Shared constants and state encoding for the MD5 digest transmit path.
package md5_pkg;

   localparam int DIGEST_BITS = 128;
   localparam int RAW_BYTES   = 16;
   localparam int HEX_CHARS   = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
   localparam logic [7:0] ASCII_ALPHA_BASE = 8'h61;

endpackage

// File: rtl/md5_nibble_to_ascii.sv
// Converts one 4-bit nibble to its lowercase ASCII hex character.
module md5_nibble_to_ascii
   import md5_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] ascii_char
);

   always_comb begin
      if (nibble < 4'd10) begin
         ascii_char = ASCII_DIGIT_BASE + {4'h0, nibble};
      end else begin
         ascii_char = ASCII_ALPHA_BASE + {4'h0, nibble} - 8'd10;
      end
   end

endmodule

// File: rtl/md5_digest_tx.sv
// Captures a 128-bit MD5 digest on load and streams it as raw bytes or
// lowercase hex text (optional trailing newline) over a valid/ready link.
module md5_digest_tx
   import md5_pkg::*;
#(
   parameter bit         APPEND_NL = 1'b1,
   parameter logic [7:0] NL_CHAR   = 8'h0A
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load,
   input  logic [0:DIGEST_BITS-1] hash,
   input  logic                   ascii_mode,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic                   busy,
   output logic                   done,
   output logic                   load_err,
   output logic [1:0]             dbg_state
);

   // Handshake: a byte moves on any rising edge where tx_valid and tx_ready
   // are both 1; while tx_valid=1 and tx_ready=0, tx_data holds its value.

   state_t                 r_state;
   logic [0:DIGEST_BITS-1] r_cap;
   logic                   r_ascii;
   logic [5:0]             r_idx;
   logic [7:0]             r_tx_data;
   logic                   r_tx_valid;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_load_err;

   logic                   w_start;
   logic                   w_xfer;
   logic [5:0]             w_last_idx;
   logic                   w_is_last;
   logic [0:DIGEST_BITS-1] w_sel_cap;
   logic                   w_sel_ascii;
   logic [5:0]             w_sel_idx;
   logic [3:0]             w_nibble;
   logic [7:0]             w_raw;
   logic [7:0]             w_hex;
   logic [7:0]             w_next_byte;

   assign w_start    = load && (r_state != ST_SEND);
   assign w_xfer     = r_tx_valid && tx_ready;
   assign w_last_idx = r_ascii ? (APPEND_NL ? 6'd32 : 6'd31) : 6'd15;
   assign w_is_last  = (r_idx == w_last_idx);

   // The byte register is loaded one step ahead: on load it selects byte 0 of
   // the incoming hash, on a transfer it selects the byte after r_idx.
   assign w_sel_cap   = w_start ? hash : r_cap;
   assign w_sel_ascii = w_start ? ascii_mode : r_ascii;
   assign w_sel_idx   = w_start ? 6'd0 : (r_idx + 6'd1);

   assign w_nibble = w_sel_cap[{w_sel_idx[4:0], 2'b00} +: 4];
   assign w_raw    = w_sel_cap[{w_sel_idx[3:0], 3'b000} +: 8];

   md5_nibble_to_ascii u_hex (
      .nibble     (w_nibble),
      .ascii_char (w_hex)
   );

   always_comb begin
      w_next_byte = w_raw;
      if (w_sel_ascii) begin
         w_next_byte = (w_sel_idx == 6'd32) ? NL_CHAR : w_hex;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cap      <= '0;
         r_ascii    <= 1'b0;
         r_idx      <= 6'd0;
         r_tx_data  <= 8'h00;
         r_tx_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_load_err <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (load) begin
                  r_cap      <= hash;
                  r_ascii    <= ascii_mode;
                  r_idx      <= 6'd0;
                  r_tx_data  <= w_next_byte;
                  r_tx_valid <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= ST_SEND;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_SEND: begin
               if (load) begin
                  r_load_err <= 1'b1;
               end
               if (w_xfer) begin
                  if (w_is_last) begin
                     r_tx_valid <= 1'b0;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_state    <= ST_DONE;
                  end else begin
                     r_idx     <= r_idx + 6'd1;
                     r_tx_data <= w_next_byte;
                  end
               end
            end
            default: begin
               r_tx_valid <= 1'b0;
               r_busy     <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_data   = r_tx_data;
   assign tx_valid  = r_tx_valid;
   assign busy      = r_busy;
   assign done      = r_done;
   assign load_err  = r_load_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_md5_digest_tx.sv
// Bench for md5_digest_tx: one instance with a trailing newline, one without,
// both driven by the same stimulus and checked against expected byte queues.
module tb_md5_digest_tx;

   localparam logic [127:0] H_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
   localparam logic [127:0] H_ONES  = {128{1'b1}};

   logic         clk;
   logic         rst_n;
   logic         load;
   logic [127:0] hash;
   logic         ascii_mode;
   logic         tx_ready;
   logic         bp_en;

   logic [7:0]   tx_data0, tx_data1;
   logic         tx_valid0, tx_valid1;
   logic         busy0, busy1;
   logic         done0, done1;
   logic         load_err0, load_err1;
   logic [1:0]   dbg_state0, dbg_state1;

   int           n_checks;
   int           n_fails;

   logic [7:0]   exp_q0[$];
   logic [7:0]   exp_q1[$];
   logic         exp_done[2];
   logic         prev_v[2];
   logic         prev_r[2];
   logic [7:0]   prev_d[2];

   md5_digest_tx #(.APPEND_NL(1'b1), .NL_CHAR(8'h0A)) u_dut_nl (
      .clk(clk), .rst_n(rst_n), .load(load), .hash(hash), .ascii_mode(ascii_mode),
      .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
      .busy(busy0), .done(done0), .load_err(load_err0), .dbg_state(dbg_state0)
   );

   md5_digest_tx #(.APPEND_NL(1'b0), .NL_CHAR(8'h0A)) u_dut_nonl (
      .clk(clk), .rst_n(rst_n), .load(load), .hash(hash), .ascii_mode(ascii_mode),
      .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
      .busy(busy1), .done(done1), .load_err(load_err1), .dbg_state(dbg_state1)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (act=timeout req=finish)");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // scoreboard model
   task automatic push_frame(input logic [127:0] h, input logic a);
      logic [3:0] nib;
      logic [7:0] c;
      if (!a) begin
         for (int k = 0; k < 16; k++) begin
            c = h[127 - 8*k -: 8];
            exp_q0.push_back(c);
            exp_q1.push_back(c);
         end
      end else begin
         for (int k = 0; k < 32; k++) begin
            nib = h[127 - 4*k -: 4];
            c = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h61 + {4'h0, nib} - 8'd10);
            exp_q0.push_back(c);
            exp_q1.push_back(c);
         end
         exp_q0.push_back(8'h0A);
      end
   endtask

   function automatic int q_size(input int i);
      return (i == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   task automatic mon(input int i, input logic v, input logic r, input logic [7:0] d,
                      input logic dn, input logic b);
      logic [7:0] e;
      if (!rst_n) begin
         prev_v[i] = 1'b0;
         return;
      end
      if (exp_done[i] || dn) begin
         check($sformatf("done%0d", i), dn, exp_done[i]);
         if (exp_done[i]) begin
            check($sformatf("valid_after_last%0d", i), v, 1'b0);
            check($sformatf("busy_after_last%0d", i), b, 1'b0);
         end
         exp_done[i] = 1'b0;
      end
      if (prev_v[i] && !prev_r[i]) begin
         check($sformatf("stall_hold%0d", i), {v, d}, {1'b1, prev_d[i]});
      end
      if (v) check($sformatf("busy_in_send%0d", i), b, 1'b1);
      if (v && r) begin
         if (q_size(i) == 0) begin
            check($sformatf("extra_byte%0d", i), {1'b1, d}, 9'h000);
         end else begin
            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("byte%0d_rem%0d", i, q_size(i)), d, e);
            if (q_size(i) == 0) exp_done[i] = 1'b1;
         end
      end
      prev_v[i] = v;
      prev_r[i] = r;
      prev_d[i] = d;
   endtask

   always @(negedge clk) begin
      mon(0, tx_valid0, tx_ready, tx_data0, done0, busy0);
      mon(1, tx_valid1, tx_ready, tx_data1, done1, busy1);
   end

   // random backpressure: 0-5 stall cycles between accepted bytes
   initial begin
      int stall;
      stall = 0;
      forever begin
         @(posedge clk);
         #1;
         if (bp_en) begin
            if (stall > 0) begin
               tx_ready = 1'b0;
               stall--;
            end else begin
               tx_ready = 1'b1;
               stall = $urandom_range(0, 5);
            end
         end
      end
   end

   // driver tasks
   task automatic start_frame(input logic [127:0] h, input logic a);
      @(posedge clk);
      #1;
      load = 1'b1;
      hash = h;
      ascii_mode = a;
      push_frame(h, a);
      @(posedge clk);
      #1;
      load = 1'b0;
      check("start_valid", {tx_valid0, tx_valid1}, 2'b11);
      check("start_busy", {busy0, busy1}, 2'b11);
      check("start_no_err", {load_err0, load_err1}, 2'b00);
      hash = {$urandom, $urandom, $urandom, $urandom};
      ascii_mode = ~a;
   endtask

   task automatic wait_frame(input int budget);
      int n;
      n = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0 || exp_done[0] || exp_done[1]) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("frame_timeout", (n < budget), 1'b1);
      @(posedge clk);
      #1;
      check("idle_after_frame", {tx_valid0, busy0, tx_valid1, busy1}, 4'b0000);
   endtask

   initial begin
      n_checks = 0;
      n_fails = 0;
      rst_n = 1'b0;
      load = 1'b0;
      hash = '0;
      ascii_mode = 1'b0;
      tx_ready = 1'b1;
      bp_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_done[i] = 1'b0;
         prev_v[i] = 1'b0;
         prev_r[i] = 1'b0;
         prev_d[i] = 8'h00;
      end
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {tx_valid0, tx_valid1}, 2'b00);
      check("rst_busy", {busy0, busy1}, 2'b00);
      check("rst_done", {done0, done1}, 2'b00);
      check("rst_load_err", {load_err0, load_err1}, 2'b00);
      check("rst_data", tx_data0, 8'h00);
      check("rst_state", dbg_state0, 2'd0);
      rst_n = 1'b1;

      // raw, continuous ready
      start_frame(H_EMPTY, 1'b0);
      wait_frame(200);

      // ascii with and without newline
      start_frame(H_EMPTY, 1'b1);
      wait_frame(200);

      // backpressure, ascii then raw
      bp_en = 1'b1;
      start_frame(H_EMPTY, 1'b1);
      wait_frame(2000);
      start_frame(H_EMPTY, 1'b0);
      wait_frame(2000);
      bp_en = 1'b0;
      tx_ready = 1'b1;

      // load while busy: on byte index 4 and on the final transfer
      start_frame(H_EMPTY, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      load = 1'b1;
      hash = H_ONES;
      @(posedge clk);
      #1;
      load = 1'b0;
      check("load_err_mid", {load_err0, load_err1}, 2'b11);
      check("still_busy_mid", {busy0, busy1}, 2'b11);
      repeat (10) @(posedge clk);
      #1;
      load = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      check("load_err_last", {load_err0, load_err1}, 2'b11);
      check("busy_drop_last", {busy0, busy1}, 2'b00);
      check("state_done", dbg_state0, 2'd2);
      wait_frame(200);

      // asynchronous reset with idx=7
      start_frame({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_valid", {tx_valid0, tx_valid1}, 2'b00);
      check("abort_busy", {busy0, busy1}, 2'b00);
      check("abort_state", dbg_state0, 2'd0);
      exp_q0.delete();
      exp_q1.delete();
      exp_done[0] = 1'b0;
      exp_done[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", {done0, done1}, 2'b00);
      start_frame({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      wait_frame(200);

      // all ones in hex text
      start_frame(H_ONES, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      ascii_mode = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      ascii_mode = 1'b0;
      wait_frame(200);

      // random frames under backpressure
      bp_en = 1'b1;
      for (int t = 0; t < 4; t++) begin
         start_frame({$urandom, $urandom, $urandom, $urandom}, t[0]);
         wait_frame(2000);
      end
      bp_en = 1'b0;
      tx_ready = 1'b1;

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
